ahbl2apb_bridge: RTL and testbench
==================================

Name: ahbl2apb_bridge

Overview:
- AHB-Lite slave to APB3 master bridge; the DUT driven by the AHB-Lite master agent and monitored by its monitor.
- Converts each AHB-Lite NONSEQ/SEQ beat into one APB transfer, stalling the AHB data phase with hready until the APB transfer completes.
- Single clock domain: pclk is hclk.

Parameters:
PADDR_W, 16, width of paddr; paddr = latched haddr[PADDR_W-1:0]

Ports:
hclk  input  1  clock for AHB and APB sides
hreset  input  1  asynchronous, active-high reset
hsel  input  1  slave select
haddr  input  32  address-phase address
htrans  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hsize  input  3  transfer size
hburst  input  3  burst type; ignored, each beat is independent
hprot  input  4  protection; used only with APB4_EN
hwrite  input  1  1 = write
hwdata  input  32  write data, valid in the data phase
hreadyin  input  1  system hready, fed back from the mux
hrdata  output  32  read data, registered
hready  output  1  hreadyout, registered
hresp  output  1  0 = OKAY, 1 = ERROR, registered
paddr  output  PADDR_W  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  32  APB write data
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset: all outputs reset to these values while hreset is high, asynchronously, including mid-transfer: hrdata=0, hready=1, hresp=0, paddr=0, psel=0, penable=0, pwrite=0, pwdata=0. FSM goes to IDLE. An APB transfer in progress is abandoned.
- Accept: at a rising edge with hsel & htrans[1] & hreadyin, latch haddr, hwrite, hsize and hprot.
  - Not accepted: htrans IDLE/BUSY, or hsel=0. These get a zero-wait OKAY (hready stays 1, hresp 0).
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE:
  - hready=1.
  - On accept with hsize>2: go to ERR1; no APB transfer is issued.
  - On accept with a write: go to WDATA, hready=0.
  - On accept with a read: go to SETUP, hready=0.
- WDATA: capture hwdata into pwdata at the end of the cycle; go to SETUP. hready=0.
- SETUP: psel=1, penable=0; paddr and pwrite valid. Go to ACCESS. hready=0.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata held stable.
  - pready=0: stay in ACCESS.
  - pready=1, pslverr=0: psel=0, penable=0, go to IDLE. Next cycle hready=1, hresp=0. For reads, hrdata=prdata captured at that edge.
  - pready=1, pslverr=1: go to ERR1.
- ERR1: hready=0, hresp=1; psel=0. Go to ERR2.
- ERR2: hready=1, hresp=1; go to IDLE.
  - An accept in ERR2 is treated exactly as an accept in IDLE (same edge, same next-state rules).
  - hresp returns to 0 the cycle after ERR2 unless a new error starts.
- Back-to-back: the completion cycle (hready=1) may carry the next address phase; it is accepted on that edge. There are no idle APB cycles beyond those listed.
- Latency from accept edge to the hready=1 cycle (zero-wait APB): read 2 cycles, write 3 cycles. Each pready=0 cycle adds 1.
- hrdata holds its last value when not updated. pwdata updates only in WDATA.
- Misaligned haddr is forwarded unchanged. The bridge does no alignment checking.
- psel and penable never assert in the same cycle that hready=1.

Optional Feature:
- Macro: AHBL2APB_APB4_EN.
- When defined, adds two outputs:
  - pprot output 3 = {~hprot[0], 1'b1, hprot[1]}, latched at accept.
  - pstrb output 4 = byte lanes decoded from the latched hsize and haddr[1:0], for writes; 0 for reads.
  - Both reset to 0 and are held through SETUP and ACCESS.
- When undefined: these ports do not exist; behaviour is otherwise identical.

Test Plan:
- Reset: hreset pulsed high mid-ACCESS -> psel=0, penable=0, hready=1, hresp=0 asynchronously; FSM in IDLE; next NONSEQ is accepted normally.
- Zero-wait read: NONSEQ read haddr=0x0000_1234, pready=1, prdata=0xDEAD_BEEF -> paddr=0x1234, SETUP then ACCESS; hready low 2 cycles, then hrdata=0xDEAD_BEEF, hresp=0.
- Write with wait states: NONSEQ write haddr=0x40, hwdata=0xA5A5_0001, pready low 3 ACCESS cycles -> pwdata=0xA5A5_0001 from SETUP onward, penable high 4 cycles, hready low 6 cycles.
- Slave error: read with pready=1, pslverr=1 -> ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1), then hresp=0.
- Illegal size: NONSEQ hsize=3 -> no psel assertion; two-cycle ERROR response.
- Back-to-back: INCR4 burst of SEQ writes to 0x100 to 0x10C, issued in each completion cycle -> 4 APB transfers, paddr 0x100/0x104/0x108/0x10C; BUSY inserted mid-burst gets a zero-wait OKAY.

Source files
------------

// File: rtl/ahbl2apb_bridge.sv
// ---------------------------------------------------------------------------
// ahbl2apb_bridge
//
// AHB-Lite slave to APB3 master bridge. Each accepted NONSEQ/SEQ beat becomes
// exactly one APB transfer. The AHB data phase is stalled with hready until
// the APB side completes. One clock (hclk) serves both sides.
//
// Optional build macro: AHBL2APB_APB4_EN
//   When defined, the APB4 outputs pprot and pstrb are added.
//
// Ports
//   hclk, hreset     : clock, asynchronous active-high reset
//   hsel..hreadyin   : AHB-Lite slave address/data-phase inputs
//   hrdata, hready,
//   hresp            : registered AHB-Lite slave responses
//   paddr..pwdata    : registered APB master request outputs
//   prdata, pready,
//   pslverr          : APB completer responses
//   pprot, pstrb     : APB4 protection and write strobes (macro only)
// ---------------------------------------------------------------------------
module ahbl2apb_bridge #(
  parameter int PADDR_W = 16
) (
  input  logic               hclk,
  input  logic               hreset,
  input  logic               hsel,
  input  logic [31:0]        haddr,
  input  logic [1:0]         htrans,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [3:0]         hprot,
  input  logic               hwrite,
  input  logic [31:0]        hwdata,
  input  logic               hreadyin,
  output logic [31:0]        hrdata,
  output logic               hready,
  output logic               hresp,
  output logic [PADDR_W-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr
`ifdef AHBL2APB_APB4_EN
  ,
  output logic [2:0]         pprot,
  output logic [3:0]         pstrb
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [31:0]        hrdata_q, hrdata_d;
  logic               hready_q, hready_d;
  logic               hresp_q, hresp_d;
  logic [PADDR_W-1:0] paddr_q, paddr_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic               pwrite_q, pwrite_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               accept;

  // hburst carries no meaning here (every beat stands alone) and only the low
  // address bits reach paddr; folding them together keeps them visibly consumed.
  logic unused_inputs;
  assign unused_inputs = ^{hburst, hprot, haddr};

  // A new beat is taken only when the whole AHB system is ready and the
  // transfer type is NONSEQ or SEQ (htrans[1] set).
  assign accept = hsel & htrans[1] & hreadyin;

  // Next-state logic. IDLE and ERR2 both present hready=1, so either may take
  // a new address phase with identical rules. The bus outputs are derived
  // from the next state so that they are registered yet line up with the
  // state they describe.
  always_comb begin
    state_d  = state_q;
    hrdata_d = hrdata_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;

    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          paddr_d  = haddr[PADDR_W-1:0];
          pwrite_d = hwrite;
          if (hsize > 3'd2) begin
            state_d = S_ERR1;
          end else if (hwrite) begin
            state_d = S_WDATA;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_WDATA: begin
        pwdata_d = hwdata;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (pready) begin
          if (pslverr) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_IDLE;
            if (!pwrite_q) begin
              hrdata_d = prdata;
            end
          end
        end
      end
      S_ERR1: begin
        state_d = S_ERR2;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    hready_d  = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d   = (state_d == S_ERR1) || (state_d == S_ERR2);
    psel_d    = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d = (state_d == S_ACCESS);
  end

  // State and output registers; reset abandons any APB transfer in flight.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= S_IDLE;
      hrdata_q  <= '0;
      hready_q  <= 1'b1;
      hresp_q   <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      hrdata_q  <= hrdata_d;
      hready_q  <= hready_d;
      hresp_q   <= hresp_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign hrdata  = hrdata_q;
  assign hready  = hready_q;
  assign hresp   = hresp_q;
  assign paddr   = paddr_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;

`ifdef AHBL2APB_APB4_EN
  logic [2:0] pprot_q, pprot_d;
  logic [3:0] pstrb_q, pstrb_d;
  logic [3:0] lanes;

  // Byte lanes touched by a legal access of the given size at haddr[1:0].
  always_comb begin
    lanes = 4'b0000;
    case (hsize)
      3'd0:    lanes = 4'b0001 << haddr[1:0];
      3'd1:    lanes = haddr[1] ? 4'b1100 : 4'b0011;
      3'd2:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
  end

  // Protection and strobes are captured with the address and then held, so
  // they stay stable through SETUP and ACCESS. Reads never strobe.
  always_comb begin
    pprot_d = pprot_q;
    pstrb_d = pstrb_q;
    if ((state_q == S_IDLE || state_q == S_ERR2) && accept) begin
      pprot_d = {~hprot[0], 1'b1, hprot[1]};
      pstrb_d = hwrite ? lanes : 4'b0000;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      pprot_q <= '0;
      pstrb_q <= '0;
    end else begin
      pprot_q <= pprot_d;
      pstrb_q <= pstrb_d;
    end
  end

  assign pprot = pprot_q;
  assign pstrb = pstrb_q;
`endif

endmodule

// File: tb/tb_ahbl2apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahbl2apb_bridge
//
// Drives AHB-Lite transactions into the bridge and plays an APB completer
// with a programmable number of wait states and an optional slave error.
// Expected response timing and data come from a transaction-level model:
// number of stalled cycles, response code, read data and the APB request
// each beat should produce.
// ---------------------------------------------------------------------------
module tb_ahbl2apb_bridge;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hreadyin;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
`ifdef AHBL2APB_APB4_EN
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  // Completer behaviour for the current transfer
  int          slvWaits = 0;
  bit          slvErr   = 1'b0;
  logic [31:0] slvRdata = '0;

  // What the completer saw on the first ACCESS cycle of each transfer
  int          apbCount = 0;
  int          accCnt   = 0;
  bit          prevSetup = 1'b0;
  logic [15:0] lastPaddr;
  logic        lastPwrite;
  logic [31:0] lastPwdata;
`ifdef AHBL2APB_APB4_EN
  logic [2:0]  lastPprot;
  logic [3:0]  lastPstrb;
`endif
  logic [15:0] obsAddrQ[$];
  logic [31:0] obsDataQ[$];

  // Model state
  logic [31:0] modelHrdata = '0;
  logic [31:0] modelPwdata = '0;

  assign hreadyin = hready;

  ahbl2apb_bridge #(.PADDR_W(16)) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .hsel    (hsel),
    .haddr   (haddr),
    .htrans  (htrans),
    .hsize   (hsize),
    .hburst  (hburst),
    .hprot   (hprot),
    .hwrite  (hwrite),
    .hwdata  (hwdata),
    .hreadyin(hreadyin),
    .hrdata  (hrdata),
    .hready  (hready),
    .hresp   (hresp),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
`ifdef AHBL2APB_APB4_EN
    ,
    .pprot   (pprot),
    .pstrb   (pstrb)
`endif
  );

  always #5 hclk = ~hclk;

  // Counts one comparison and reports it when the values differ
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // APB completer: answers on the falling edge so the bridge sees stable
  // pready/pslverr/prdata at the next rising edge. Outside ACCESS it drives
  // junk that the bridge must ignore.
  always @(negedge hclk) begin
    checkOutput("apbWhileHready", {31'b0, (psel | penable) & hready}, 32'd0);
    if (psel && penable) begin
      if (accCnt == 0) begin
        apbCount++;
        checkOutput("setupBeforeAccess", {31'b0, prevSetup}, 32'd1);
        lastPaddr  = paddr;
        lastPwrite = pwrite;
        lastPwdata = pwdata;
`ifdef AHBL2APB_APB4_EN
        lastPprot  = pprot;
        lastPstrb  = pstrb;
`endif
        obsAddrQ.push_back(paddr);
        obsDataQ.push_back(pwdata);
      end else begin
        checkOutput("paddrStable", {16'b0, paddr}, {16'b0, lastPaddr});
        checkOutput("pwdataStable", pwdata, lastPwdata);
      end
      pready  = (accCnt >= slvWaits);
      pslverr = pready && slvErr;
      prdata  = pready ? slvRdata : $urandom;
      accCnt++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      prdata  = $urandom;
      accCnt  = 0;
    end
    prevSetup = psel && !penable;
  end

  // One AHB beat, started on a falling edge where hready=1. Stalled cycles,
  // response and APB request are compared with the transaction model.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               input int waits, input bit err,
                               input logic [31:0] rdata);
    int          lowCnt;
    int          expLow;
    int          startCnt;
    bit          illegal;
    logic [3:0]  prot;
    illegal  = (size > 3'd2);
    prot     = 4'($urandom);
    slvWaits = waits;
    slvErr   = err;
    slvRdata = rdata;
    startCnt = apbCount;

    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hprot  = prot;
    hburst = 3'($urandom);
    @(negedge hclk);
    hsel   = 1'($urandom_range(0, 1));
    htrans = 2'b00;
    haddr  = $urandom;
    hwdata = wdata;

    lowCnt = 0;
    while (hready == 1'b0 && lowCnt < 100) begin
      lowCnt++;
      @(negedge hclk);
    end

    // Stall length: optional write-data cycle, SETUP, one ACCESS per wait
    // plus the completing one, and ERR1 on a slave error.
    if (illegal) expLow = 1;
    else         expLow = (wr ? 1 : 0) + 2 + waits + (err ? 1 : 0);
    checkOutput("hreadyLowCycles", lowCnt, expLow);
    checkOutput("hrespAtDone", {31'b0, hresp}, {31'b0, illegal || err});
    if (!illegal && !err && !wr) modelHrdata = rdata;
    checkOutput("hrdata", hrdata, modelHrdata);
    checkOutput("apbTransfers", apbCount - startCnt, illegal ? 0 : 1);
    if (!illegal) begin
      checkOutput("paddr", {16'b0, lastPaddr}, {16'b0, addr[15:0]});
      checkOutput("pwrite", {31'b0, lastPwrite}, {31'b0, wr});
      if (wr) modelPwdata = wdata;
      checkOutput("pwdata", lastPwdata, modelPwdata);
`ifdef AHBL2APB_APB4_EN
      checkOutput("pprot", {29'b0, lastPprot}, {29'b0, ~prot[0], 1'b1, prot[1]});
      checkOutput("pstrb", {28'b0, lastPstrb},
                  wr ? ((32'd1 << (32'd1 << size)) - 1) << (addr[1:0] & ~((2'd1 << size) - 2'd1))
                     : 32'd0);
`endif
    end
    // After an error response, sometimes let the next beat start in ERR2
    if ((illegal || err) && $urandom_range(0, 1) == 1) begin
      @(negedge hclk);
      checkOutput("hrespCleared", {31'b0, hresp}, 32'd0);
      checkOutput("hreadyAfterErr", {31'b0, hready}, 32'd1);
    end
  endtask

  // INCR4 write burst 0x100..0x10C with a BUSY beat between the 2nd and 3rd
  // beats; each SEQ beat is presented in the previous beat's completion cycle.
  task automatic applyBurst();
    logic [31:0] data [4];
    int          beat;
    int          lowCnt;
    beat     = 0;
    slvWaits = $urandom_range(0, 1);
    slvErr   = 1'b0;
    obsAddrQ.delete();
    obsDataQ.delete();
    for (int i = 0; i < 4; i++) data[i] = $urandom;
    for (int b = 0; b < 5; b++) begin
      hsel   = 1'b1;
      hwrite = 1'b1;
      hsize  = 3'd2;
      hburst = 3'd3;
      if (b == 2) begin
        htrans = 2'b01;
        haddr  = 32'h108;
      end else begin
        htrans = (b == 0) ? 2'b10 : 2'b11;
        haddr  = 32'h100 + 32'(4 * beat);
      end
      @(negedge hclk);
      if (b == 2) begin
        checkOutput("busyHready", {31'b0, hready}, 32'd1);
        checkOutput("busyHresp", {31'b0, hresp}, 32'd0);
      end else begin
        hwdata = data[beat];
        beat++;
        lowCnt = 0;
        while (hready == 1'b0 && lowCnt < 100) begin
          lowCnt++;
          @(negedge hclk);
        end
        checkOutput("burstLowCycles", lowCnt, 3 + slvWaits);
        checkOutput("burstHresp", {31'b0, hresp}, 32'd0);
      end
    end
    htrans = 2'b00;
    hsel   = 1'b0;
    checkOutput("burstTransfers", obsAddrQ.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obsAddrQ.size()) begin
        checkOutput("burstPaddr", {16'b0, obsAddrQ[i]}, 32'h100 + 32'(4 * i));
        checkOutput("burstPwdata", obsDataQ[i], data[i]);
      end
    end
    modelPwdata = data[3];
  endtask

  // Reset asserted in the middle of a stalled ACCESS phase
  task automatic applyMidReset();
    int guard;
    slvWaits = 6;
    slvErr   = 1'b0;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h0000_2468;
    hwrite = 1'b0;
    hsize  = 3'd2;
    @(negedge hclk);
    htrans = 2'b00;
    guard  = 0;
    while (penable == 1'b0 && guard < 20) begin
      guard++;
      @(negedge hclk);
    end
    checkOutput("reachedAccess", {31'b0, penable}, 32'd1);
    @(negedge hclk);
    #2 hreset = 1'b1;
    #1;
    checkOutput("asyncRstPsel", {31'b0, psel}, 32'd0);
    checkOutput("asyncRstPenable", {31'b0, penable}, 32'd0);
    checkOutput("asyncRstHready", {31'b0, hready}, 32'd1);
    checkOutput("asyncRstHresp", {31'b0, hresp}, 32'd0);
    checkOutput("asyncRstPaddr", {16'b0, paddr}, 32'd0);
    checkOutput("asyncRstHrdata", hrdata, 32'd0);
    @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    modelHrdata = '0;
    modelPwdata = '0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    hreset = 1'b1;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = 2'b00;
    hsize  = 3'd0;
    hburst = 3'd0;
    hprot  = 4'd0;
    hwrite = 1'b0;
    hwdata = '0;
    repeat (3) @(negedge hclk);
    checkOutput("rstHrdata", hrdata, 32'd0);
    checkOutput("rstHready", {31'b0, hready}, 32'd1);
    checkOutput("rstHresp", {31'b0, hresp}, 32'd0);
    checkOutput("rstPaddr", {16'b0, paddr}, 32'd0);
    checkOutput("rstPsel", {31'b0, psel}, 32'd0);
    checkOutput("rstPenable", {31'b0, penable}, 32'd0);
    checkOutput("rstPwrite", {31'b0, pwrite}, 32'd0);
    checkOutput("rstPwdata", pwdata, 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    $display("[TB] directed beats");
    applyStimulus(1'b0, 32'h0000_1234, 3'd2, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 32'h0000_0040, 3'd2, 32'hA5A5_0001, 3, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0000_0080, 3'd2, 32'h0, 0, 1'b1, 32'h1111_2222);
    applyStimulus(1'b0, 32'h0000_00C0, 3'd3, 32'h0, 0, 1'b0, 32'h3333_4444);
    applyStimulus(1'b1, 32'hFFFF_0003, 3'd0, 32'h1234_5678, 1, 1'b1, 32'h0);

    $display("[TB] burst with BUSY");
    applyBurst();
    @(negedge hclk);

    $display("[TB] reset during ACCESS");
    applyMidReset();
    applyStimulus(1'b0, 32'h0000_1000, 3'd1, 32'h0, 0, 1'b0, 32'hCAFE_F00D);

    $display("[TB] random beats");
    for (int n = 0; n < 60; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom,
                    ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                : 3'($urandom_range(0, 2)),
                    $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 4) == 0), $urandom);
    end

    repeat (2) @(negedge hclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
